mire_writer: RTL
================

// Module: mire_writer
// PURPOSE
//   Wishbone master that fills the SDRAM framebuffer with a test pattern (mire), one pixel per word.
//   Sits upstream of the VGA reader on the shared SDRAM bus, through the bus arbiter.
//   Writes in bursts, then releases cyc so the VGA read path keeps its FIFO fed.
//   Rewrites frames continuously while enabled.
// PARAMETERS
//   HDISP        800  active pixels per line
//   VDISP        480  active lines per frame
//   GRID         16   grid pitch in pixels; power of 2, >=2
//   BURST        64   max accepted writes per bus tenure, >=1
//   GAP_CYCLES   4    cycles with cyc=0 between tenures, >=1
// PORTS
//   clk          in   1   Wishbone/SDRAM-side clock (the interface's clk)
//   rst          in   1   synchronous, active-high reset (the interface's rst)
//   en           in   1   level; 1 = keep writing frames
//   adr          out  32  byte address, = 4*(y*HDISP+x)
//   dat_ms       out  32  write data {8'h00, R[7:0], G[7:0], B[7:0]}
//   we           out  1   constant 1
//   sel          out  4   constant 4'b0111
//   cti          out  3   constant 0 (classic cycles)
//   bte          out  2   constant 0
//   cyc          out  1   bus request, equal to stb
//   stb          out  1   strobe
//   ack          in   1   slave accepted current write
//   rty          in   1   slave asks for a retry of current write
//   frame_done   out  1   1-cycle pulse after last pixel of a frame is acked
//   frame_cnt    out  16  completed frames, wraps at 2^16
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): state IDLE, x=y=0, burst count=0, gap count=0, cyc=stb=0,
//     adr=0, frame_done=0, frame_cnt=0. Reset mid-transfer drops cyc/stb at that edge; the
//     current write is abandoned and the next frame restarts at pixel 0.
//   - cyc, stb, adr, dat_ms and frame_done are registered. dat_ms/adr depend only on (x,y) and
//     are valid whenever stb=1.
//   - States:
//     IDLE:  cyc=0. If en=1, go to WRITE at next edge (cyc=stb=1 one cycle after en rises).
//     WRITE: cyc=stb=1, adr/dat held stable until ack=1 or rty=1.
//            ack=1: advance pixel (x++, or x=0 and y++ at x=HDISP-1), burst count++.
//            rty=1 without ack: same pixel reissued, no advance, burst count unchanged.
//            ack and rty both 1: treat as ack.
//            Leave to GAP (cyc=stb=0 next cycle) when the acked write was the BURST-th of the
//            tenure, the last pixel of the frame, or en=0 at that ack.
//            en falling with no ack pending: stay in WRITE until the outstanding write is
//            acked. A strobed write is never withdrawn.
//     GAP:   cyc=stb=0 for exactly GAP_CYCLES cycles. Then go to WRITE if en=1, else IDLE.
//            Burst count is cleared on GAP entry.
//   - End of frame: the ack on x=HDISP-1, y=VDISP-1 wraps x=y=0. frame_done=1 in the next
//     cycle, and frame_cnt increments in the same cycle (wraps 65535->0).
//   - en=0 then en=1 resumes at the saved (x,y); only rst returns to pixel 0.
//   - Address arithmetic is 32-bit unsigned; the pixel index is kept as an incremental
//     counter, no multiplier.
//   - Pattern: RGB=24'hFFFFFF if (x % GRID == 0) or (y % GRID == 0), else 24'h000000.
// CONFIGURATION
//   MIRE_GRADIENT_EN defined:
//     RGB = {x[7:0], y[7:0], frame_cnt[7:0]}. Animated gradient; grid disabled.
//   MIRE_GRADIENT_EN undefined:
//     Grid pattern above only; no extra logic.
//   Handshake and timing are identical in both builds.
// TESTING
//   1. rst then en=1, slave acks every cycle, HDISP=8, VDISP=4, GRID=4, BURST=4, GAP_CYCLES=2
//      -> adr 0,4,8,12, cyc low 2 cycles, then adr 16..; dat_ms=0x00FFFFFF at x=0,4 or y=0.
//   2. Same config, full frame -> after ack at adr 124: frame_done pulse once, frame_cnt=1,
//      next write at adr 0.
//   3. rty on 3rd write of a burst -> adr 8 repeated, burst still ends after 4 acks (last adr 12).
//   4. en dropped while stb=1, ack 3 cycles later -> stb held until ack, GAP 2 cycles, IDLE.
//      en=1 again -> resumes at next pixel.
//   5. rst asserted while stb=1 -> cyc=stb=0 at next edge, frame_cnt=0, restart adr 0.
//   6. MIRE_GRADIENT_EN build, frame 1 pixel (x=5, y=2) -> dat_ms=0x00050201.

Source files
------------

// File: rtl/mire_wb_if.sv
// Wishbone write-master bus bundle between mire_writer and the SDRAM arbiter.
interface mire_wb_if;
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic        we;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        cyc;
   logic        stb;
   logic        ack;
   logic        rty;

   modport master (
      output adr, dat_ms, we, sel, cti, bte, cyc, stb,
      input  ack, rty
   );

   modport slave (
      input  adr, dat_ms, we, sel, cti, bte, cyc, stb,
      output ack, rty
   );
endinterface

// File: rtl/mire_writer.sv
// Wishbone master writing a grid test pattern into the framebuffer in bounded bursts.
// Define MIRE_GRADIENT_EN to replace the grid with an animated {x, y, frame} gradient.
module mire_writer #(
   parameter int unsigned HDISP      = 800,
   parameter int unsigned VDISP      = 480,
   parameter int unsigned GRID       = 16,
   parameter int unsigned BURST      = 64,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   mire_wb_if.master   wb,
   output logic        o_frame_done,
   output logic [15:0] o_frame_cnt
);

   localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
   localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
   localparam int unsigned BW = $clog2(BURST + 1);
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t          r_state;
   logic [XW-1:0]   r_x;
   logic [YW-1:0]   r_y;
   logic [29:0]     r_pix;
   logic [BW-1:0]   r_burst;
   logic [GW-1:0]   r_gap;
   logic            r_stb;
   logic [31:0]     r_adr;
   logic [23:0]     r_dat;
   logic            r_frame_done;
   logic [15:0]     r_frame_cnt;

   logic            w_last_x;
   logic            w_eof;
   logic            w_burst_end;
   logic [XW-1:0]   w_nx;
   logic [YW-1:0]   w_ny;
   logic [29:0]     w_npix;
   logic [15:0]     w_nfc;
   logic [23:0]     w_ndat;
   logic [23:0]     w_rst_dat;

`ifdef MIRE_GRADIENT_EN
   function automatic logic [23:0] f_rgb(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                         input logic [7:0] fc);
      return {8'(x), 8'(y), fc};
   endfunction
`else
   function automatic logic [23:0] f_rgb(input logic [XW-1:0] x, input logic [YW-1:0] y);
      logic on_grid;
      on_grid = ((32'(x) & 32'(GRID - 1)) == 32'd0) || ((32'(y) & 32'(GRID - 1)) == 32'd0);
      return on_grid ? 24'hFFFFFF : 24'h000000;
   endfunction
`endif

   // Position of the pixel following the one currently on the bus.
   always_comb begin
      w_last_x    = (r_x == XW'(HDISP - 1));
      w_eof       = w_last_x && (r_y == YW'(VDISP - 1));
      w_nx        = w_last_x ? '0 : r_x + XW'(1);
      w_ny        = w_last_x ? (w_eof ? '0 : r_y + YW'(1)) : r_y;
      w_npix      = w_eof ? '0 : r_pix + 30'd1;
      w_nfc       = w_eof ? r_frame_cnt + 16'd1 : r_frame_cnt;
      w_burst_end = (r_burst == BW'(BURST - 1)) || w_eof || !i_en;
`ifdef MIRE_GRADIENT_EN
      w_ndat      = f_rgb(w_nx, w_ny, w_nfc[7:0]);
      w_rst_dat   = f_rgb('0, '0, 8'd0);
`else
      w_ndat      = f_rgb(w_nx, w_ny);
      w_rst_dat   = f_rgb('0, '0);
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_x          <= '0;
         r_y          <= '0;
         r_pix        <= '0;
         r_burst      <= '0;
         r_gap        <= '0;
         r_stb        <= 1'b0;
         r_adr        <= 32'd0;
         r_dat        <= w_rst_dat;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= 16'd0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_en) begin
                  r_state <= S_WRITE;
                  r_stb   <= 1'b1;
               end
            end
            S_WRITE: begin
               if (wb.ack) begin
                  r_x          <= w_nx;
                  r_y          <= w_ny;
                  r_pix        <= w_npix;
                  r_adr        <= {w_npix, 2'b00};
                  r_dat        <= w_ndat;
                  r_frame_cnt  <= w_nfc;
                  r_frame_done <= w_eof;
                  if (w_burst_end) begin
                     r_state <= S_GAP;
                     r_stb   <= 1'b0;
                     r_burst <= '0;
                     r_gap   <= '0;
                  end else begin
                     r_burst <= r_burst + BW'(1);
                  end
               end else if (wb.rty) begin
                  // Retry: the same write stays on the bus unchanged.
                  r_stb <= 1'b1;
               end
            end
            S_GAP: begin
               if (r_gap == GW'(GAP_CYCLES - 1)) begin
                  r_state <= i_en ? S_WRITE : S_IDLE;
                  r_stb   <= i_en;
               end else begin
                  r_gap <= r_gap + GW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_stb   <= 1'b0;
            end
         endcase
      end
   end

   assign wb.adr       = r_adr;
   assign wb.dat_ms    = {8'h00, r_dat};
   assign wb.we        = 1'b1;
   assign wb.sel       = 4'b0111;
   assign wb.cti       = 3'b000;
   assign wb.bte       = 2'b00;
   assign wb.cyc       = r_stb;
   assign wb.stb       = r_stb;
   assign o_frame_done = r_frame_done;
   assign o_frame_cnt  = r_frame_cnt;

endmodule
